// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 codes,
// FSM encoding and the special result constants used by the fast path.
package mul_div_unit_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } mdu_state_e;

   localparam logic [WIDTH_DEF-1:0] ALL_ONES   = {WIDTH_DEF{1'b1}};
   localparam logic [WIDTH_DEF-1:0] SIGNED_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

   // Every funct3 with bit 2 set is a divide/remainder; 000 is MUL; the rest are unused.
   function automatic logic op_is_defined(input logic [2:0] op);
      return (op == OP_MUL) || op[2];
   endfunction

endpackage

// File: rtl/mul_div_unit_div.sv
// Restoring-divide iteration register: one quotient bit per step. The next-step
// values are exported so the owner can capture the final result on the last step.
module mdu_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quot_nxt_o,
   output logic [WIDTH-1:0] rem_nxt_o
);

   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dsor_q, dsor_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // The dividend shifts out of quot_q from the top while quotient bits enter at the bottom.
   always_comb begin
      shifted = {rem_q, quot_q[WIDTH-1]};
      diff    = shifted - {1'b0, dsor_q};
      if (!diff[WIDTH]) begin
         rem_nxt_o  = diff[WIDTH-1:0];
         quot_nxt_o = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt_o  = shifted[WIDTH-1:0];
         quot_nxt_o = {quot_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      quot_d = quot_q;
      rem_d  = rem_q;
      dsor_d = dsor_q;
      if (load_i) begin
         quot_d = dividend_i;
         rem_d  = '0;
         dsor_d = divisor_i;
      end else if (step_i) begin
         quot_d = quot_nxt_o;
         rem_d  = rem_nxt_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         quot_q <= '0;
         rem_q  <= '0;
         dsor_q <= '0;
      end else begin
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dsor_q <= dsor_d;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage iterative MUL/DIV/DIVU/REM/REMU unit. Holds the FSM, iteration counter,
// shift-add multiplier and sign handling; the divide datapath lives in mdu_div_core.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [1:0]       state_o
);

   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
   localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               valid_q, valid_d;

   logic               accept;
   logic               op_is_div, op_is_rem, op_signed;
   logic               fast_hit;
   logic [WIDTH-1:0]   fast_res;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   quot_nxt, rem_nxt;
   logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;
   logic               div_load, div_step;

   // Handshake: an op is taken whenever start_i is high outside BUSY and no flush
   // is pending; stall_o covers that accept cycle and every BUSY cycle, so EX keeps
   // presenting the same instruction until valid_o reports its result.
   assign accept  = start_i && (state_q != ST_BUSY) && !flush_i;
   assign stall_o = (state_q == ST_BUSY) || accept;
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign state_o = state_q;

   assign op_is_div = op_i[2];
   assign op_is_rem = op_i[1];
   assign op_signed = op_i[2] && !op_i[0];

   assign mag1 = (op_signed && data1_i[WIDTH-1]) ? -data1_i : data1_i;
   assign mag2 = (op_signed && data2_i[WIDTH-1]) ? -data2_i : data2_i;

   // Cases resolved without iterating: unused funct3, divide by zero, signed overflow.
   always_comb begin
      fast_hit = 1'b0;
      fast_res = '0;
      if (!op_is_defined(op_i)) begin
         fast_hit = 1'b1;
      end else if (op_is_div && (data2_i == '0)) begin
         fast_hit = 1'b1;
         fast_res = op_is_rem ? data1_i : ONES;
      end else if (op_signed && (data1_i == SMIN) && (data2_i == ONES)) begin
         fast_hit = 1'b1;
         fast_res = op_is_rem ? '0 : SMIN;
      end
   end

   assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign quo_fix   = neg_quo_q ? -quot_nxt : quot_nxt;
   assign rem_fix   = neg_rem_q ? -rem_nxt : rem_nxt;
   assign final_res = (op_q == OP_MUL) ? acc_nxt[WIDTH-1:0] :
                      op_q[1]          ? rem_fix : quo_fix;

   mdu_div_core #(
      .WIDTH (WIDTH)
   ) u_div_core (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (div_load),
      .step_i     (div_step),
      .dividend_i (mag1),
      .divisor_i  (mag2),
      .quot_nxt_o (quot_nxt),
      .rem_nxt_o  (rem_nxt)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      div_load  = 1'b0;
      div_step  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               op_d = op_i;
               if (fast_hit) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
                  data_d  = fast_res;
                  valid_d = 1'b1;
               end else begin
                  state_d   = ST_BUSY;
                  cnt_d     = CNT_LOAD;
                  neg_quo_d = op_signed && (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
                  neg_rem_d = op_signed && data1_i[WIDTH-1];
                  if (op_is_div) begin
                     div_load = 1'b1;
                  end else begin
                     acc_d    = '0;
                     mcand_d  = {{WIDTH{1'b0}}, data1_i};
                     mplier_d = data2_i;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (flush_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d    = cnt_q - 1'b1;
               div_step = op_q[2];
               if (!op_q[2]) begin
                  acc_d    = acc_nxt;
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
               end
               // The last iteration and the sign fix-up share one cycle.
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_DONE;
                  data_d  = final_res;
                  valid_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: table-driven vectors, hand-written multi-cycle sequences
// and randomized operations scored against an arithmetic reference model.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   localparam int W = 32;

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   logic         clk;
   logic         rst_i;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] d1;
   logic [W-1:0] d2;
   logic         flush;
   logic         stall;
   logic         valid;
   logic [W-1:0] data;
   logic [1:0]   state;

   int checks;
   int failures;
   logic [W-1:0] exp_q[$];
   vec_t vecs[$];

   mul_div_unit #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .start_i (start),
      .op_i    (op),
      .data1_i (d1),
      .data2_i (d2),
      .flush_i (flush),
      .stall_o (stall),
      .valid_o (valid),
      .data_o  (data),
      .state_o (state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic is_defined(input logic [2:0] o);
      return (o == OP_MUL) || (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
   endfunction

   function automatic logic is_fast(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!is_defined(o)) return 1'b1;
      if ((o != OP_MUL) && (b == '0)) return 1'b1;
      if (((o == OP_DIV) || (o == OP_REM)) && (a == SIGNED_MIN) && (b == ALL_ONES)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      int sa;
      int sb;
      sa = int'(a);
      sb = int'(b);
      r  = '0;
      case (o)
         OP_MUL:  r = a * b;
         OP_DIVU: r = (b == '0) ? ALL_ONES : a / b;
         OP_REMU: r = (b == '0) ? a : a % b;
         OP_DIV: begin
            if (b == '0) r = ALL_ONES;
            else if ((a == SIGNED_MIN) && (b == ALL_ONES)) r = SIGNED_MIN;
            else r = sa / sb;
         end
         OP_REM: begin
            if (b == '0) r = a;
            else if ((a == SIGNED_MIN) && (b == ALL_ONES)) r = '0;
            else r = sa % sb;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Issue one op from IDLE, scramble the operand inputs after accept, then measure
   // latency and stall cycles and compare the result against the expected queue.
   task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp);
      int k;
      int stall_cnt;
      int exp_lat;
      bit seen;
      logic [W-1:0] held;
      exp_lat = is_fast(o, a, b) ? 1 : W + 1;
      exp_q.push_back(exp);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      d1    = a;
      d2    = b;
      #1;
      stall_cnt = stall ? 1 : 0;
      k    = 0;
      seen = 1'b0;
      while (!seen && (k < 100)) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            op    = 3'($urandom_range(0, 7));
            d1    = $urandom;
            d2    = $urandom;
         end
         k++;
         #1;
         if (valid) seen = 1'b1;
         else if (stall) stall_cnt++;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: no valid_o within %0d cycles", name, k);
         void'(exp_q.pop_front());
      end else begin
         held = exp_q.pop_front();
         check_int({name, "_latency"}, k, exp_lat);
         check_int({name, "_stall_cycles"}, stall_cnt, exp_lat);
         check_bit({name, "_stall_at_valid"}, stall, 1'b0);
         check({name, "_data"}, data, held);
         @(negedge clk);
         #1;
         check_bit({name, "_valid_pulse"}, valid, 1'b0);
         check({name, "_data_hold"}, data, held);
         check({name, "_idle_after"}, W'(state), W'(ST_IDLE));
      end
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return ALL_ONES;
         2: return SIGNED_MIN;
         3: return W'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int v1;
      int v2;
      int pulses;
      logic [2:0] ops[5];
      logic [2:0] ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      checks   = 0;
      failures = 0;
      rst_i    = 1'b0;
      start    = 1'b0;
      op       = '0;
      d1       = '0;
      d2       = '0;
      flush    = 1'b0;

      vecs.push_back('{"mul_7_m6",     OP_MUL,  32'd7,          32'hFFFFFFFA, 32'hFFFFFFD6});
      vecs.push_back('{"div_m7_2",     OP_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD});
      vecs.push_back('{"rem_m7_2",     OP_REM,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF});
      vecs.push_back('{"divu_big_2",   OP_DIVU, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC});
      vecs.push_back('{"remu_100_7",   OP_REMU, 32'd100,        32'd7,        32'd2});
      vecs.push_back('{"div_7_m2",     OP_DIV,  32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD});
      vecs.push_back('{"rem_7_m2",     OP_REM,  32'd7,          32'hFFFFFFFE, 32'd1});
      vecs.push_back('{"divu_5_0",     OP_DIVU, 32'd5,          32'd0,        32'hFFFFFFFF});
      vecs.push_back('{"rem_5_0",      OP_REM,  32'd5,          32'd0,        32'd5});
      vecs.push_back('{"div_m9_0",     OP_DIV,  32'hFFFFFFF7,   32'd0,        32'hFFFFFFFF});
      vecs.push_back('{"remu_m9_0",    OP_REMU, 32'hFFFFFFF7,   32'd0,        32'hFFFFFFF7});
      vecs.push_back('{"div_ovf",      OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h80000000});
      vecs.push_back('{"rem_ovf",      OP_REM,  32'h80000000,   32'hFFFFFFFF, 32'd0});
      vecs.push_back('{"divu_nonovf",  OP_DIVU, 32'h80000000,   32'hFFFFFFFF, 32'd0});
      vecs.push_back('{"undef_001",    3'b001,  32'd12,         32'd3,        32'd0});
      vecs.push_back('{"undef_011",    3'b011,  32'd12,         32'd3,        32'd0});
      vecs.push_back('{"mul_big",      OP_MUL,  32'h12345678,   32'h9ABCDEF0, 32'h242D2080});

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check({"reset_state"}, W'(state), W'(ST_IDLE));
      check_bit("reset_valid", valid, 1'b0);
      check_bit("reset_stall", stall, 1'b0);
      check("reset_data", data, '0);
      @(negedge clk);
      rst_i = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Back-to-back: start held through DONE with a new op queued behind a DIV
      exp_q.push_back(32'hFFFFFFFD);
      exp_q.push_back(32'd12);
      v1 = -1;
      v2 = -1;
      @(negedge clk);
      start = 1'b1;
      op    = OP_DIV;
      d1    = 32'hFFFFFFF9;
      d2    = 32'd2;
      for (int c = 1; (c <= 80) && (v2 < 0); c++) begin
         @(negedge clk);
         if (c == 1) begin
            op = OP_MUL;
            d1 = 32'd3;
            d2 = 32'd4;
         end
         if ((v1 > 0) && (c == v1 + 1)) start = 1'b0;
         #1;
         if (valid) begin
            if (v1 < 0) begin
               v1 = c;
               check_bit("b2b_stall_in_done", stall, 1'b1);
               check("b2b_first_data", data, exp_q.pop_front());
            end else begin
               v2 = c;
               check("b2b_second_data", data, exp_q.pop_front());
            end
         end
      end
      start = 1'b0;
      exp_q.delete();
      check_int("b2b_first_valid_cycle", v1, 33);
      check_int("b2b_second_valid_cycle", v2, 66);

      // Flush at cycle 10 of a DIV: no result, data_o keeps 12
      @(negedge clk);
      start = 1'b1;
      op    = OP_DIV;
      d1    = 32'd100;
      d2    = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check_bit("flush_busy_stall", stall, 1'b1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_state", W'(state), W'(ST_IDLE));
      check_bit("flush_stall", stall, 1'b0);
      check_bit("flush_valid", valid, 1'b0);
      check("flush_data_hold", data, 32'd12);
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (valid) pulses++;
      end
      check_int("flush_no_valid", pulses, 0);

      // Flush coincident with start: nothing accepted
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = OP_MUL;
      d1    = 32'd5;
      d2    = 32'd5;
      #1;
      check_bit("flush_start_stall", stall, 1'b0);
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #1;
      check("flush_start_state", W'(state), W'(ST_IDLE));
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (valid) pulses++;
      end
      check_int("flush_start_no_valid", pulses, 0);
      check("flush_start_data_hold", data, 32'd12);

      // Async reset in the middle of BUSY, between clock edges
      @(negedge clk);
      start = 1'b1;
      op    = OP_MUL;
      d1    = 32'd9;
      d2    = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst_i = 1'b0;
      #1;
      check("areset_state", W'(state), W'(ST_IDLE));
      check_bit("areset_stall", stall, 1'b0);
      check_bit("areset_valid", valid, 1'b0);
      check("areset_data", data, '0);
      @(negedge clk);
      rst_i = 1'b1;
      run_op("after_reset_mul", OP_MUL, 32'd6, 32'd7, 32'd42);

      // Randomized operations against the reference model
      ops = '{OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) ro = 3'($urandom_range(1, 3));
         else ro = ops[$urandom_range(0, 4)];
         ra = rand_operand();
         rb = rand_operand();
         run_op("rand", ro, ra, rb, model(ro, ra, rb));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multiply/divide unit in the EX stage, next to the ALU. It consumes the same forwarded operands as the ALU. Its result enters the EX/MEM register through the EX result mux. It replaces the single-cycle multiply path with an area-cheap, multi-cycle M-extension subset (MUL, DIV, DIVU, REM, REMU). It also drives a stall request to the hazard unit while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH; counter width is clog2(WIDTH)+1

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  EX holds an M-extension op this cycle
op_i  input  3  funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU
data1_i  input  WIDTH  rs1 operand (dividend / multiplicand)
data2_i  input  WIDTH  rs2 operand (divisor / multiplier)
flush_i  input  1  pipeline flush; aborts any operation
stall_o  output  1  hold IF/ID/EX; combinational
valid_o  output  1  data_o holds a finished result; one-cycle pulse
data_o  output  WIDTH  result; held until the next accepted start

Behaviour:
- States: IDLE, BUSY, DONE. Reset (rst_i low, async): state IDLE, counter 0, data_o 0, valid_o 0, all working registers 0.
- Accept: start_i=1 and state in {IDLE, DONE} and flush_i=0. On that edge, latch op_i and the operands, and load the counter with WIDTH.
- stall_o = (state==BUSY) | (start_i & state!=BUSY & !flush_i). It drops in the cycle where valid_o=1.
- MUL: shift-add, one multiplier bit per cycle. Result is the low WIDTH bits of the product, with signed/unsigned identical. The 2*WIDTH-bit accumulator is internal.
- DIV/REM: take the magnitudes, run a restoring divide (one quotient bit per cycle), then apply signs. The quotient is negated if the operand signs differ. The remainder takes the sign of the dividend.
- DIVU/REMU: unsigned restoring divide, no sign fix-up.
- Latency, normal: accepted at edge T, BUSY for WIDTH cycles, DONE entered at edge T+WIDTH+1. valid_o=1 for exactly that one cycle.
- Fast path (IDLE/DONE -> DONE at edge T+1, valid_o at T+1):
  - divide by zero: DIV/DIVU give all-ones; REM/REMU give data1_i.
  - signed overflow (data1_i = 0x80000000, data2_i = 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
  - undefined funct3 (001, 010, 011): result 0.
- DONE with start_i=0 goes to IDLE next edge; DONE with start_i=1 accepts a new op (back-to-back). valid_o deasserts after DONE; data_o holds its value.
- flush_i=1: next edge goes to IDLE, valid_o=0, data_o unchanged, result discarded. flush_i beats a simultaneous start_i. Flush in IDLE has no effect.
- start_i while BUSY is ignored: the EX instruction is the one stalled.
- Operand changes on data1_i/data2_i after accept have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs 0.

Decomposition:
- Shared package: WIDTH default, funct3 op constants (OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU), the state encoding (IDLE/BUSY/DONE), and the all-ones / signed-min constants.
- Natural sub-module: mdu_div_core, a restoring-divide iteration register (quotient/remainder shift, subtract, restore) with load/step controls. The top level keeps the FSM, the counter, the multiplier and the sign handling.

Test Plan:
- MUL: data1=7, data2=0xFFFFFFFA (-6) -> stall_o high 33 cycles from accept; valid_o at T+33; data_o=0xFFFFFFD6 (-42).
- DIV/REM signed: -7 / 2 -> DIV data_o=0xFFFFFFFD (-3); REM data_o=0xFFFFFFFF (-1). DIVU: 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Div-by-zero and overflow: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. Each has valid_o at T+1 and stall_o high only in the accept cycle.
- Back-to-back: start_i held through DONE with a new op (MUL 3*4) -> second op accepted in the DONE cycle; valid_o pulses at T+33 and T+66; results correct.
- Flush mid-op at cycle 10 of a DIV -> IDLE next edge, no valid_o pulse, data_o keeps its prior value; flush coincident with start_i -> nothing accepted.
- Async reset asserted mid-BUSY (between clock edges) -> state IDLE, stall_o=0, valid_o=0, data_o=0 immediately; a new op after release completes correctly.
